cw305_reg_master: RTL and testbench

- Bus initiator for the CW305 byte-serial register interface.
- Accepts one multi-byte read or write command at a time. Drives reg_address, reg_bytecnt, reg_addrvalid, reg_read, reg_write and write_data toward a register responder, and collects read_data bytes into a response word.
- Used as the on-chip/bench counterpart of the USB front end: it exercises register blocks, including the PULPino mailbox registers, without the USB host.

---
 rtl/cw305_reg_master.sv | 211 +++++++++++++++++++++
 tb/tb_cw305_reg_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cw305_reg_master.sv
// cw305_reg_master: bus initiator for the CW305 byte-serial register interface.
// Takes one read or write command at a time, walks the byte counter across the
// transfer and gathers read bytes back into a response word.
module cw305_reg_master #(
    parameter int unsigned pADDR_WIDTH   = 21,
    parameter int unsigned pBYTECNT_SIZE = 7,
    parameter int unsigned pMAX_BYTES    = 16,
    parameter int unsigned pREAD_LATENCY = 1
) (
    input  logic                                   usb_clk,
    input  logic                                   reset_i,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_write,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   cmd_address,
    input  logic [pBYTECNT_SIZE:0]                 cmd_len,
    input  logic [pMAX_BYTES*8-1:0]                cmd_wdata,
    output logic                                   rsp_valid,
    output logic                                   rsp_error,
    output logic [pMAX_BYTES*8-1:0]                rsp_rdata,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    output logic [7:0]                             write_data,
    input  logic [7:0]                             read_data,
    output logic                                   reg_read,
    output logic                                   reg_write,
    output logic                                   reg_addrvalid,
    output logic                                   busy
);

    localparam int unsigned AW  = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int unsigned BW  = pBYTECNT_SIZE;
    localparam int unsigned LW  = pBYTECNT_SIZE + 1;
    localparam int unsigned DW  = pMAX_BYTES * 8;
    localparam int unsigned LAT = pREAD_LATENCY;

    // Every pipeline stage except the oldest; empty means the oldest is the last capture.
    localparam int unsigned          YOUNG      = (1 << (LAT - 1)) - 1;
    localparam logic [LAT-1:0]       YOUNG_MASK = YOUNG[LAT-1:0];

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]     state;
    logic [2:0]     state_nxt;

    logic           write_q;
    logic [LW-1:0]  len_q;
    logic [DW-1:0]  wdata_q;

    logic [BW-1:0]  idx_nxt;
    logic [AW-1:0]  address_nxt;
    logic           addrvalid_nxt;
    logic           read_nxt;
    logic           write_nxt;
    logic [7:0]     write_data_nxt;
    logic           rsp_valid_nxt;

    logic [LAT-1:0] pipe_v;
    logic [BW-1:0]  pipe_tag [LAT];

    logic           accept_c;
    logic           len_bad_c;
    logic           last_c;
    logic           drain_done_c;

    assign accept_c     = cmd_valid && cmd_ready;
    assign len_bad_c    = (cmd_len == '0) || (cmd_len > LW'(pMAX_BYTES));
    assign last_c       = ({1'b0, reg_bytecnt} == LW'(len_q - LW'(1)));
    assign drain_done_c = ((pipe_v & YOUNG_MASK) == '0);

    // Next state, byte index and next values of the registered bus outputs.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = reg_bytecnt;
        address_nxt    = reg_address;
        addrvalid_nxt  = 1'b0;
        read_nxt       = 1'b0;
        write_nxt      = 1'b0;
        write_data_nxt = 8'h00;
        rsp_valid_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_nxt   = len_bad_c ? S_DONE : S_SETUP;
                    idx_nxt     = '0;
                    address_nxt = cmd_address;
                end
            end
            S_SETUP: begin
                state_nxt = write_q ? S_WRITE : S_READ;
                idx_nxt   = '0;
            end
            S_WRITE: begin
                if (last_c) state_nxt = S_DONE;
                else        idx_nxt   = BW'(reg_bytecnt + BW'(1));
            end
            S_READ: begin
                if (last_c) state_nxt = S_DRAIN;
                else        idx_nxt   = BW'(reg_bytecnt + BW'(1));
            end
            S_DRAIN: begin
                if (drain_done_c) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        case (state_nxt)
            S_SETUP, S_DRAIN: begin
                addrvalid_nxt = 1'b1;
            end
            S_WRITE: begin
                addrvalid_nxt  = 1'b1;
                write_nxt      = 1'b1;
                write_data_nxt = 8'(wdata_q >> {idx_nxt, 3'b000});
            end
            S_READ: begin
                addrvalid_nxt = 1'b1;
                read_nxt      = 1'b1;
            end
            S_DONE: begin
                rsp_valid_nxt = 1'b1;
            end
            default: begin
                addrvalid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered bus/handshake outputs.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state         <= S_IDLE;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_addrvalid <= 1'b0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            write_data    <= 8'h00;
        end else begin
            state         <= state_nxt;
            cmd_ready     <= (state_nxt == S_IDLE);
            busy          <= (state_nxt != S_IDLE);
            rsp_valid     <= rsp_valid_nxt;
            reg_address   <= address_nxt;
            reg_bytecnt   <= idx_nxt;
            reg_addrvalid <= addrvalid_nxt;
            reg_read      <= read_nxt;
            reg_write     <= write_nxt;
            write_data    <= write_data_nxt;
        end
    end

    // Command latch; cmd_* is ignored once the command is accepted.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            write_q <= 1'b0;
            len_q   <= '0;
            wdata_q <= '0;
        end else if (accept_c) begin
            write_q <= cmd_write;
            len_q   <= cmd_len;
            wdata_q <= cmd_wdata;
        end
    end

    // Read-return pipeline: one valid/tag entry per issued read, aged once per cycle.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            pipe_v <= '0;
            for (int i = 0; i < int'(LAT); i++) pipe_tag[i] <= '0;
        end else begin
            pipe_v[0]   <= reg_read;
            pipe_tag[0] <= reg_bytecnt;
            for (int i = 1; i < int'(LAT); i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    // Response word: cleared above the length on a read accept, filled as tags emerge.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept_c) rsp_error <= len_bad_c;
            for (int i = 0; i < int'(pMAX_BYTES); i++) begin
                if (accept_c && !cmd_write && (LW'(i) >= cmd_len))
                    rsp_rdata[i*8 +: 8] <= 8'h00;
                else if (pipe_v[LAT-1] && (pipe_tag[LAT-1] == BW'(i)))
                    rsp_rdata[i*8 +: 8] <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_cw305_reg_master.sv
// Bench for cw305_reg_master: two instances (read latency 1 and 3) share the
// command stimulus; each has its own register responder. Results are checked
// against a byte-array model of the register space.
module tb_cw305_reg_master;

    localparam int unsigned AW   = 14;
    localparam int unsigned LW   = 8;
    localparam int unsigned MAXB = 16;
    localparam int unsigned DW   = 128;

    logic          usb_clk = 1'b0;
    logic          reset_i;
    logic          cmd_valid;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_wdata;

    logic          cmd_ready_l1, rsp_valid_l1, rsp_error_l1, reg_read_l1, reg_write_l1, reg_addrvalid_l1, busy_l1;
    logic [DW-1:0] rsp_rdata_l1;
    logic [AW-1:0] reg_address_l1;
    logic [6:0]    reg_bytecnt_l1;
    logic [7:0]    write_data_l1, read_data_l1;

    logic          cmd_ready_l3, rsp_valid_l3, rsp_error_l3, reg_read_l3, reg_write_l3, reg_addrvalid_l3, busy_l3;
    logic [DW-1:0] rsp_rdata_l3;
    logic [AW-1:0] reg_address_l3;
    logic [6:0]    reg_bytecnt_l3;
    logic [7:0]    write_data_l3, read_data_l3;

    logic [7:0]  model_mem [16][16];
    logic [7:0]  mem_l1 [16][16];
    logic [7:0]  mem_l3 [16][16];
    logic [7:0]  rp_l3 [3];
    logic [DW-1:0] last_rd;

    logic        mon_en;
    int          av_l1, av_l3;
    logic [31:0] wq_l1[$], wq_l3[$], rq_l1[$], rq_l3[$];

    int n_chk = 0;
    int n_bad = 0;

    always #5 usb_clk = ~usb_clk;

    cw305_reg_master #(.pREAD_LATENCY(1)) u_dut_l1 (
        .usb_clk(usb_clk), .reset_i(reset_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_l1), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_l1), .rsp_error(rsp_error_l1), .rsp_rdata(rsp_rdata_l1),
        .reg_address(reg_address_l1), .reg_bytecnt(reg_bytecnt_l1),
        .write_data(write_data_l1), .read_data(read_data_l1),
        .reg_read(reg_read_l1), .reg_write(reg_write_l1),
        .reg_addrvalid(reg_addrvalid_l1), .busy(busy_l1)
    );

    cw305_reg_master #(.pREAD_LATENCY(3)) u_dut_l3 (
        .usb_clk(usb_clk), .reset_i(reset_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_l3), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_l3), .rsp_error(rsp_error_l3), .rsp_rdata(rsp_rdata_l3),
        .reg_address(reg_address_l3), .reg_bytecnt(reg_bytecnt_l3),
        .write_data(write_data_l3), .read_data(read_data_l3),
        .reg_read(reg_read_l3), .reg_write(reg_write_l3),
        .reg_addrvalid(reg_addrvalid_l3), .busy(busy_l3)
    );

    // Responder for the latency-1 instance; junk on read_data when no read is pending.
    always @(posedge usb_clk) begin
        if (reset_i) mem_l1 <= model_mem;
        else if (reg_addrvalid_l1 && reg_write_l1)
            mem_l1[reg_address_l1[3:0]][reg_bytecnt_l1[3:0]] <= write_data_l1;
        read_data_l1 <= reg_read_l1 ? mem_l1[reg_address_l1[3:0]][reg_bytecnt_l1[3:0]] : 8'($urandom);
    end

    // Responder for the latency-3 instance: three-stage return path.
    always @(posedge usb_clk) begin
        if (reset_i) mem_l3 <= model_mem;
        else if (reg_addrvalid_l3 && reg_write_l3)
            mem_l3[reg_address_l3[3:0]][reg_bytecnt_l3[3:0]] <= write_data_l3;
        rp_l3[0] <= reg_read_l3 ? mem_l3[reg_address_l3[3:0]][reg_bytecnt_l3[3:0]] : 8'($urandom);
        rp_l3[1] <= rp_l3[0];
        rp_l3[2] <= rp_l3[1];
    end
    assign read_data_l3 = rp_l3[2];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus-rule monitor and beat recorder.
    always @(negedge usb_clk) begin
        if (mon_en) begin
            chk("rw_excl_l1", 128'(reg_read_l1 & reg_write_l1), 128'(0));
            chk("rw_excl_l3", 128'(reg_read_l3 & reg_write_l3), 128'(0));
            chk("strobe_av_l1", 128'((reg_read_l1 | reg_write_l1) & ~reg_addrvalid_l1), 128'(0));
            chk("strobe_av_l3", 128'((reg_read_l3 | reg_write_l3) & ~reg_addrvalid_l3), 128'(0));
            if (reg_addrvalid_l1) av_l1++;
            if (reg_addrvalid_l3) av_l3++;
            if (reg_write_l1) wq_l1.push_back({2'b00, reg_address_l1, 1'b0, reg_bytecnt_l1, write_data_l1});
            if (reg_write_l3) wq_l3.push_back({2'b00, reg_address_l3, 1'b0, reg_bytecnt_l3, write_data_l3});
            if (reg_read_l1)  rq_l1.push_back({2'b00, reg_address_l1, 1'b0, reg_bytecnt_l1, 8'h00});
            if (reg_read_l3)  rq_l3.push_back({2'b00, reg_address_l3, 1'b0, reg_bytecnt_l3, 8'h00});
        end
    end

    task automatic clear_mon();
        wq_l1.delete(); wq_l3.delete(); rq_l1.delete(); rq_l3.delete();
        av_l1 = 0; av_l3 = 0;
    endtask

    // One command end to end, with expectations taken from the register model.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input int len, input logic [DW-1:0] wd);
        logic          bad;
        int            exp_l1, exp_l3, k1, k3, p1, p3, n_w, n_r;
        logic [DW-1:0] exp_rd, rd1, rd3;
        logic          e1, e3;
        logic [31:0]   beat;
        bad    = (len == 0) || (len > int'(MAXB));
        exp_l1 = bad ? 1 : (wr ? len + 2 : len + 1 + 2);
        exp_l3 = bad ? 1 : (wr ? len + 2 : len + 3 + 2);
        exp_rd = last_rd;
        if (!wr) begin
            for (int i = 0; i < int'(MAXB); i++) begin
                if (i >= len)  exp_rd[i*8 +: 8] = 8'h00;
                else if (!bad) exp_rd[i*8 +: 8] = model_mem[addr[3:0]][i];
            end
        end
        clear_mon();
        @(negedge usb_clk);
        chk("ready_l1", 128'(cmd_ready_l1), 128'(1));
        chk("ready_l3", 128'(cmd_ready_l3), 128'(1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_len = LW'(len); cmd_wdata = wd;
        @(posedge usb_clk);
        k1 = -1; k3 = -1; p1 = 0; p3 = 0; rd1 = '0; rd3 = '0; e1 = 1'b0; e3 = 1'b0;
        for (int k = 1; k <= exp_l3 + 3; k++) begin
            @(negedge usb_clk);
            if (k == 1) begin
                cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_address = AW'($urandom);
                cmd_len = LW'($urandom); cmd_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (rsp_valid_l1) begin p1++; if (k1 < 0) begin k1 = k; rd1 = rsp_rdata_l1; e1 = rsp_error_l1; end end
            if (rsp_valid_l3) begin p3++; if (k3 < 0) begin k3 = k; rd3 = rsp_rdata_l3; e3 = rsp_error_l3; end end
        end
        chk("lat_l1", 128'(k1), 128'(exp_l1));
        chk("lat_l3", 128'(k3), 128'(exp_l3));
        chk("pulses_l1", 128'(p1), 128'(1));
        chk("pulses_l3", 128'(p3), 128'(1));
        chk("err_l1", 128'(e1), 128'(bad));
        chk("err_l3", 128'(e3), 128'(bad));
        chk("rdata_l1", rd1, exp_rd);
        chk("rdata_l3", rd3, exp_rd);
        chk("rdata_hold_l1", rsp_rdata_l1, exp_rd);
        chk("idle_busy_l1", 128'(busy_l1), 128'(0));
        n_w = (wr && !bad) ? len : 0;
        n_r = (!wr && !bad) ? len : 0;
        chk("n_wr_l1", 128'(wq_l1.size()), 128'(n_w));
        chk("n_wr_l3", 128'(wq_l3.size()), 128'(n_w));
        chk("n_rd_l1", 128'(rq_l1.size()), 128'(n_r));
        chk("n_rd_l3", 128'(rq_l3.size()), 128'(n_r));
        chk("n_av_l1", 128'(av_l1), 128'(bad ? 0 : (wr ? len + 1 : len + 2)));
        chk("n_av_l3", 128'(av_l3), 128'(bad ? 0 : (wr ? len + 1 : len + 4)));
        for (int i = 0; i < n_w && i < wq_l1.size() && i < wq_l3.size(); i++) begin
            beat = {2'b00, addr, 1'b0, 7'(i), wd[i*8 +: 8]};
            chk("wbeat_l1", 128'(wq_l1[i]), 128'(beat));
            chk("wbeat_l3", 128'(wq_l3[i]), 128'(beat));
        end
        for (int i = 0; i < n_r && i < rq_l1.size() && i < rq_l3.size(); i++) begin
            beat = {2'b00, addr, 1'b0, 7'(i), 8'h00};
            chk("rbeat_l1", 128'(rq_l1[i]), 128'(beat));
            chk("rbeat_l3", 128'(rq_l3[i]), 128'(beat));
        end
        if (wr && !bad)
            for (int i = 0; i < len; i++) model_mem[addr[3:0]][i] = wd[i*8 +: 8];
        last_rd = exp_rd;
    endtask

    // Reset during the 5th READ cycle of a 16-byte read.
    task automatic reset_mid_read();
        int nv;
        @(negedge usb_clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = AW'(9); cmd_len = LW'(16);
        @(posedge usb_clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge usb_clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        chk("rd_cyc5", 128'({reg_read_l1, reg_bytecnt_l1}), 128'({1'b1, 7'd4}));
        reset_i = 1'b1;
        @(negedge usb_clk);
        reset_i = 1'b0;
        chk("rst_bus_l1", 128'({reg_addrvalid_l1, reg_read_l1, reg_write_l1, reg_bytecnt_l1, reg_address_l1, write_data_l1}), 128'(0));
        chk("rst_bus_l3", 128'({reg_addrvalid_l3, reg_read_l3, reg_write_l3, reg_bytecnt_l3, reg_address_l3, write_data_l3}), 128'(0));
        chk("rst_ready_l1", 128'({cmd_ready_l1, busy_l1, rsp_valid_l1}), 128'(3'b100));
        chk("rst_ready_l3", 128'({cmd_ready_l3, busy_l3, rsp_valid_l3}), 128'(3'b100));
        chk("rst_rdata_l1", rsp_rdata_l1, 128'(0));
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge usb_clk);
            if (rsp_valid_l1 || rsp_valid_l3 || reg_read_l1 || reg_read_l3 || reg_write_l1 || reg_write_l3) nv++;
        end
        chk("rst_quiet", 128'(nv), 128'(0));
        last_rd = '0;
    endtask

    // Two writes with cmd_valid held high; the second is taken in the idle cycle after DONE.
    task automatic back_to_back();
        logic [DW-1:0] wa, wb;
        int            first1, second1, first3, second3, acc2, idle_between;
        logic          drop;
        logic [31:0]   exp_q[$];
        wa = {$urandom, $urandom, $urandom, $urandom};
        wb = {$urandom, $urandom, $urandom, $urandom};
        clear_mon();
        @(negedge usb_clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = AW'(10); cmd_len = LW'(2); cmd_wdata = wa;
        @(posedge usb_clk);
        first1 = -1; second1 = -1; first3 = -1; second3 = -1; acc2 = -1; idle_between = 0; drop = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge usb_clk);
            if (k == 1) begin cmd_address = AW'(11); cmd_len = LW'(3); cmd_wdata = wb; end
            if (drop) cmd_valid = 1'b0;
            if (rsp_valid_l1) begin if (first1 < 0) first1 = k; else if (second1 < 0) second1 = k; end
            if (rsp_valid_l3) begin if (first3 < 0) first3 = k; else if (second3 < 0) second3 = k; end
            if (cmd_ready_l1 && first1 >= 0 && second1 < 0) idle_between++;
            if (cmd_ready_l1 && cmd_valid) begin acc2 = k; drop = 1'b1; end
        end
        chk("b2b_first_l1", 128'(first1), 128'(4));
        chk("b2b_accept2", 128'(acc2), 128'(5));
        chk("b2b_second_l1", 128'(second1), 128'(10));
        chk("b2b_first_l3", 128'(first3), 128'(4));
        chk("b2b_second_l3", 128'(second3), 128'(10));
        chk("b2b_idle", 128'(idle_between), 128'(1));
        chk("b2b_av_l1", 128'(av_l1), 128'(7));
        for (int i = 0; i < 2; i++) exp_q.push_back({2'b00, AW'(10), 1'b0, 7'(i), wa[i*8 +: 8]});
        for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, AW'(11), 1'b0, 7'(i), wb[i*8 +: 8]});
        chk("b2b_nwr_l1", 128'(wq_l1.size()), 128'(5));
        for (int i = 0; i < 5 && i < wq_l1.size(); i++) chk("b2b_beat_l1", 128'(wq_l1[i]), 128'(exp_q[i]));
        for (int i = 0; i < 2; i++) model_mem[10][i] = wa[i*8 +: 8];
        for (int i = 0; i < 3; i++) model_mem[11][i] = wb[i*8 +: 8];
    endtask

    initial begin
        logic [DW-1:0] wd;
        reset_i = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_len = '0; cmd_wdata = '0;
        mon_en = 1'b0; last_rd = '0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) model_mem[a][b] = 8'($urandom);
        model_mem[4][0] = 8'h2E;
        model_mem[5][0] = 8'hEF; model_mem[5][1] = 8'hBE; model_mem[5][2] = 8'hAD; model_mem[5][3] = 8'hDE;
        repeat (3) @(posedge usb_clk);
        @(negedge usb_clk);
        reset_i = 1'b0;
        chk("por_ready", 128'({cmd_ready_l1, cmd_ready_l3, busy_l1, busy_l3}), 128'(4'b1100));
        chk("por_rsp", 128'({rsp_valid_l1, rsp_error_l1, rsp_valid_l3, rsp_error_l3}), 128'(0));
        chk("por_rdata", rsp_rdata_l1, 128'(0));
        chk("por_bus", 128'({reg_addrvalid_l1, reg_read_l1, reg_write_l1, reg_bytecnt_l1, reg_address_l1, write_data_l1}), 128'(0));
        mon_en = 1'b1;

        wd = 128'h00112233445566778899AABBCCDDEEFF;
        run_cmd(1'b1, AW'(7), 16, wd);
        for (int i = 0; i < 16; i++) chk("textin", 128'(mem_l1[7][i]), 128'(model_mem[7][i]));
        run_cmd(1'b0, AW'(4), 1, '0);
        run_cmd(1'b0, AW'(5), 4, '0);
        run_cmd(1'b1, AW'(3), 0, {$urandom, $urandom, $urandom, $urandom});
        run_cmd(1'b0, AW'(3), 17, '0);
        reset_mid_read();
        run_cmd(1'b1, AW'(2), 1, {$urandom, $urandom, $urandom, $urandom});
        run_cmd(1'b0, AW'(2), 1, '0);
        back_to_back();
        run_cmd(1'b0, AW'(11), 3, '0);

        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), int'($urandom_range(0, 17)),
                    {$urandom, $urandom, $urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
